// File: rtl/basic_merger_sync_if.sv
// Pulse-line bundle for basic_merger_sync.
// The master drives the two toggle-encoded input lines; the slave (the merger)
// drives the merged toggle line plus its status outputs.
// Handshake: none. Every transition on in1/in2/out is one pulse, and there is
// no valid/ready pair. The upstream side must space transitions on each input
// at least one clk period apart, or the extra transitions are lost.
// warm_state exposes the merger's warm-up state so checkers can observe it.
interface basic_merger_sync_if #(
   parameter int CNT_W = 4
);
   logic             in1;
   logic             in2;
   logic             out;
   logic [CNT_W-1:0] pending;
   logic             coincide;
   logic             overflow;
   logic [1:0]       warm_state;

   modport master (
      output in1,
      output in2,
      input  out,
      input  pending,
      input  coincide,
      input  overflow,
      input  warm_state
   );

   modport slave (
      input  in1,
      input  in2,
      output out,
      output pending,
      output coincide,
      output overflow,
      output warm_state
   );
endinterface

// File: rtl/basic_merger_sync.sv
// Clocked merger of two toggle-encoded pulse lines into one toggle-encoded line.
// Each input is synchronised and edge-detected. Detected pulses go into a
// saturating pending counter, which drains at up to one output toggle per clock.
// Coincident detections raise a one-cycle strobe. Any pulse dropped at
// saturation sets a sticky overflow flag.
module basic_merger_sync #(
   parameter int CNT_W            = 4,
   parameter bit MERGE_COINCIDENT = 1'b0
) (
   input logic                 clk,
   input logic                 rst_n,
   basic_merger_sync_if.slave  bus
);

   localparam int SW = CNT_W + 1;

   // Warm-up sequencer: two cycles after reset release before detection arms.
   typedef enum logic [1:0] {
      WARM_0 = 2'd0,
      WARM_1 = 2'd1,
      ARMED  = 2'd2
   } warm_e;

   // Bit 0 belongs to in1 and bit 1 belongs to in2 in all per-input vectors.
   logic [1:0]       sync1_q, sync1_d;
   logic [1:0]       sync2_q, sync2_d;
   logic [1:0]       hist_q, hist_d;
   warm_e            warm_q, warm_d;
   logic             out_q, out_d;
   logic [CNT_W-1:0] pending_q, pending_d;
   logic             coincide_q, coincide_d;
   logic             overflow_q, overflow_d;

   logic             armed;
   logic [1:0]       det;
   logic [SW-1:0]    arrivals;
   logic [SW-1:0]    total;
   logic [SW-1:0]    after_emit;
   logic             emit;

   // Next-state logic: synchronise, detect, queue, emit, saturate.
   always_comb begin
      warm_d = warm_q;
      case (warm_q)
         WARM_0:  warm_d = WARM_1;
         WARM_1:  warm_d = ARMED;
         default: warm_d = ARMED;
      endcase
      armed = (warm_q == ARMED);

      sync1_d = {bus.in2, bus.in1};
      sync2_d = sync1_q;
      // While unarmed, history follows the value that sync2 is about to take.
      // An input resting at 1 through reset therefore matches its history
      // once detection arms.
      hist_d  = armed ? sync2_q : sync1_q;
      det     = armed ? (sync2_q ^ hist_q) : 2'b00;

      if (MERGE_COINCIDENT) begin
         arrivals = SW'(det[0] | det[1]);
      end else begin
         arrivals = SW'(det[0]) + SW'(det[1]);
      end

      // The extra counter bit absorbs pending_max + 2 without wrapping.
      total      = {1'b0, pending_q} + arrivals;
      emit       = (total != '0);
      after_emit = total - SW'(emit);

      pending_d  = after_emit[CNT_W-1:0];
      overflow_d = overflow_q;
      if (after_emit > {1'b0, {CNT_W{1'b1}}}) begin
         pending_d  = {CNT_W{1'b1}};
         overflow_d = 1'b1;
      end

      out_d      = out_q ^ emit;
      coincide_d = det[0] & det[1];
   end

   // State registers; asynchronous reset discards any queued pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 2'b00;
         sync2_q    <= 2'b00;
         hist_q     <= 2'b00;
         warm_q     <= WARM_0;
         out_q      <= 1'b0;
         pending_q  <= '0;
         coincide_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         hist_q     <= hist_d;
         warm_q     <= warm_d;
         out_q      <= out_d;
         pending_q  <= pending_d;
         coincide_q <= coincide_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.out        = out_q;
   assign bus.pending    = pending_q;
   assign bus.coincide   = coincide_q;
   assign bus.overflow   = overflow_q;
   assign bus.warm_state = warm_q;

endmodule
